// File: rtl/clock_pkg.sv
// Shared types and default timing constants for the per-key button blocks.
package clock_pkg;

    // Classifier FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HELD  = 2'd2
    } btn_state_t;

    // 20 ms debounce window and 1 s long-press threshold at 50 MHz.
    localparam int unsigned DEB_20MS_50MHZ = 1_000_000;
    localparam int unsigned LONG_1S_50MHZ  = 50_000_000;

endpackage

// File: rtl/button_press_classifier_if.sv
// Key input and classified press outputs of one pushbutton channel.
interface button_press_classifier_if;

    logic key_n;    // raw active-low key level
    logic B_S;      // short-press pulse
    logic B_L;      // long-press pulse
    logic pressed;  // debounced held level

    // Environment side: drives the key, observes the results.
    modport master (
        output key_n,
        input  B_S,
        input  B_L,
        input  pressed
    );

    // Classifier side.
    modport slave (
        input  key_n,
        output B_S,
        output B_L,
        output pressed
    );

endinterface

// File: rtl/key_debouncer.sv
// Synchronizes a raw active-low key and accepts a level change only after it
// has been stable for DEBOUNCE_CYCLES consecutive cycles.
module key_debouncer
    import clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEB_20MS_50MHZ
) (
    input  logic clk_50MHz,
    input  logic rst_n,
    input  logic key_n,
    output logic pressed,
    output logic rise       // high in the cycle before pressed goes 0 -> 1
);

    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic          key_s;   // registered, active-high synchronized key
    logic [DW-1:0] deb_cnt;
    logic          expire;

    // The differing level has now been seen for the full window.
    assign expire = (key_s != pressed) && (deb_cnt == DW'(DEBOUNCE_CYCLES - 1));
    assign rise   = expire & ~pressed;

    // Synchronizer chain, inversion stage and debounce counter.
    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            key_s   <= 1'b0;
            deb_cnt <= '0;
            pressed <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            key_s <= ~sync2;
            if (key_s == pressed) begin
                deb_cnt <= '0;
            end else if (expire) begin
                pressed <= ~pressed;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

endmodule

// File: rtl/button_press_classifier.sv
// Turns one bouncing active-low pushbutton into single-cycle short-press (B_S)
// and long-press (B_L) pulses plus a debounced held level.
module button_press_classifier
    import clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEB_20MS_50MHZ,
    parameter int unsigned LONG_CYCLES     = LONG_1S_50MHZ
) (
    input  logic                      clk_50MHz,
    input  logic                      rst_n,
    button_press_classifier_if.slave  btn
);

    localparam int unsigned HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;

    btn_state_t    state;
    logic [HW-1:0] hold_cnt;
    logic          pressed;
    logic          rise;
    logic          b_s;
    logic          b_l;

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debouncer (
        .clk_50MHz (clk_50MHz),
        .rst_n     (rst_n),
        .key_n     (btn.key_n),
        .pressed   (pressed),
        .rise      (rise)
    );

    assign btn.pressed = pressed;
    assign btn.B_S     = b_s;
    assign btn.B_L     = b_l;

    // Press classifier: hold_cnt starts on the edge where pressed rises, so
    // B_L lands LONG_CYCLES edges later; release is seen one cycle after the
    // fall, and in PRESS it is tested first so a coinciding release wins.
    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            b_s      <= 1'b0;
            b_l      <= 1'b0;
        end else begin
            b_s <= 1'b0;
            b_l <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state    <= PRESS;
                        hold_cnt <= '0;
                    end
                end
                PRESS: begin
                    if (!pressed) begin
                        state <= IDLE;
                        b_s   <= 1'b1;
                    end else if (hold_cnt == HW'(LONG_CYCLES - 1)) begin
                        state <= HELD;
                        b_l   <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                HELD: begin
                    if (!pressed) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_press_classifier.sv
// Bench for button_press_classifier with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// A time-based press model is compared every cycle; directed scenarios pin
// latencies and pulse counts with literal values.
module tb_button_press_classifier;

    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 20;

    logic clk_50MHz = 1'b0;
    logic rst_n     = 1'b0;

    button_press_classifier_if bif ();

    button_press_classifier #(
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LONG)
    ) dut (
        .clk_50MHz (clk_50MHz),
        .rst_n     (rst_n),
        .btn       (bif)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Observed DUT events.
    int n_rise = 0, n_fall = 0, n_bs = 0, n_bl = 0;
    int rise_cyc = -1, fall_cyc = -1, bs_cyc = -1, bl_cyc = -1;
    logic prev_p = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int get_cnt(input int which);
        case (which)
            0:       return n_rise;
            1:       return n_fall;
            2:       return n_bs;
            default: return n_bl;
        endcase
    endfunction

    // Wait (bounded) until the selected event counter moves past its value at call time.
    task automatic wait_for(input int which, input int maxc, input string name);
        int base;
        base = get_cnt(which);
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk_50MHz);
            if (get_cnt(which) > base) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL %s: actual=timeout required=event within %0d cycles", name, maxc);
    endtask

    // Model: pressed follows the key once the key, seen 3 edges late, has
    // disagreed with it for DEB samples in a row. A press lasting fewer than
    // LONG edges yields B_S the edge after the fall; otherwise B_L fires LONG
    // edges after the rise.
    initial begin
        bit hist[$];
        bit mp, pend_bs, exp_bs, exp_bl, all_eq;
        int age;
        mp = 0; pend_bs = 0; exp_bs = 0; exp_bl = 0; age = 0;
        forever begin
            @(posedge clk_50MHz);
            cyc++;
            if (!rst_n) begin
                hist.delete();
                for (int j = 0; j < DEB + 3; j++) hist.push_back(1'b1);
                mp = 0; age = 0; pend_bs = 0; exp_bs = 0; exp_bl = 0;
            end else begin
                hist.push_front(bif.key_n);
                void'(hist.pop_back());
                exp_bs  = pend_bs;
                pend_bs = 0;
                exp_bl  = 0;
                if (mp) begin
                    age++;
                    exp_bl = (age == LONG);
                end
                all_eq = 1;
                for (int j = 0; j < DEB; j++) if (hist[3 + j] != mp) all_eq = 0;
                if (all_eq) begin
                    if (!mp) begin
                        mp  = 1;
                        age = 0;
                    end else begin
                        mp      = 0;
                        pend_bs = (age < LONG);
                    end
                end
            end
            #1;
            chk("pressed", bif.pressed, mp);
            chk("B_S", bif.B_S, exp_bs);
            chk("B_L", bif.B_L, exp_bl);
            if (bif.pressed === 1'b1 && prev_p === 1'b0) begin n_rise++; rise_cyc = cyc; end
            if (bif.pressed === 1'b0 && prev_p === 1'b1) begin n_fall++; fall_cyc = cyc; end
            prev_p = bif.pressed;
            if (bif.B_S === 1'b1) begin n_bs++; bs_cyc = cyc; end
            if (bif.B_L === 1'b1) begin n_bl++; bl_cyc = cyc; end
        end
    end

    // Directed scenarios.
    initial begin
        int t0, t1, r, p, b0, l0;
        bif.key_n = 1'b1;
        rst_n     = 1'b0;

        // Reset held while the key toggles, then released with the key idle.
        repeat (10) begin
            @(negedge clk_50MHz);
            bif.key_n = ~bif.key_n;
        end
        @(negedge clk_50MHz);
        bif.key_n = 1'b1;
        rst_n     = 1'b1;
        repeat (10) @(negedge clk_50MHz);
        chk("reset_no_bs", n_bs, 0);
        chk("reset_no_bl", n_bl, 0);
        chk("reset_no_rise", n_rise, 0);

        // Bounce: five 3-cycle lows never get accepted.
        repeat (5) begin
            bif.key_n = 1'b0;
            repeat (3) @(negedge clk_50MHz);
            bif.key_n = 1'b1;
            repeat (3) @(negedge clk_50MHz);
        end
        chk("bounce_no_rise", n_rise, 0);
        chk("bounce_no_bs", n_bs, 0);

        // Clean press: pressed rises 6 edges after the first low sample.
        bif.key_n = 1'b0;
        t0 = cyc + 1;
        wait_for(0, 20, "press_rise");
        chk("press_latency", rise_cyc - t0, 6);

        // Short press: hold 10 cycles, release.
        b0 = n_bs; l0 = n_bl;
        repeat (10) @(negedge clk_50MHz);
        bif.key_n = 1'b1;
        t1 = cyc + 1;
        wait_for(1, 20, "short_fall");
        wait_for(2, 5, "short_bs");
        repeat (5) @(negedge clk_50MHz);
        chk("short_bs_after_fall", bs_cyc - fall_cyc, 1);
        chk("short_release_latency", bs_cyc - t1, 7);
        chk("short_bs_count", n_bs - b0, 1);
        chk("short_no_bl", n_bl - l0, 0);

        // Long press: hold 40 cycles.
        bif.key_n = 1'b0;
        wait_for(0, 20, "long_rise");
        b0 = n_bs; l0 = n_bl;
        repeat (40) @(negedge clk_50MHz);
        bif.key_n = 1'b1;
        wait_for(1, 20, "long_fall");
        repeat (5) @(negedge clk_50MHz);
        chk("long_bl_delay", bl_cyc - rise_cyc, 20);
        chk("long_bl_count", n_bl - l0, 1);
        chk("long_no_bs", n_bs - b0, 0);

        // Release landing on hold cycle 19: release wins.
        bif.key_n = 1'b0;
        wait_for(0, 20, "edge_rise");
        p = rise_cyc;
        b0 = n_bs; l0 = n_bl;
        while (cyc < p + 12) @(negedge clk_50MHz);
        bif.key_n = 1'b1;
        wait_for(1, 20, "edge_fall");
        repeat (5) @(negedge clk_50MHz);
        chk("edge_fall_at19", fall_cyc - p, 19);
        chk("edge_bs_delay", bs_cyc - p, 20);
        chk("edge_bs_count", n_bs - b0, 1);
        chk("edge_no_bl", n_bl - l0, 0);

        // Reset at hold cycle 10 with the key still held.
        bif.key_n = 1'b0;
        wait_for(0, 20, "rst_rise");
        p = rise_cyc;
        b0 = n_bs; l0 = n_bl;
        while (cyc < p + 10) @(negedge clk_50MHz);
        rst_n = 1'b0;
        repeat (3) @(negedge clk_50MHz);
        rst_n = 1'b1;
        r = cyc + 1;
        wait_for(0, 20, "rst_rerise");
        chk("rst_repress_latency", rise_cyc - r, 6);
        chk("rst_no_pulse", (n_bs - b0) + (n_bl - l0), 0);
        repeat (8) @(negedge clk_50MHz);
        bif.key_n = 1'b1;
        wait_for(1, 20, "rst_fall");
        wait_for(2, 5, "rst_bs");
        repeat (3) @(negedge clk_50MHz);
        chk("rst_bs_count", n_bs - b0, 1);
        chk("rst_no_bl", n_bl - l0, 0);

        // Back-to-back short presses separated by 6 idle cycles.
        b0 = n_bs; l0 = n_bl;
        bif.key_n = 1'b0;
        wait_for(0, 20, "b2b_rise1");
        repeat (3) @(negedge clk_50MHz);
        bif.key_n = 1'b1;
        wait_for(2, 20, "b2b_bs1");
        repeat (6) @(negedge clk_50MHz);
        bif.key_n = 1'b0;
        wait_for(0, 20, "b2b_rise2");
        repeat (3) @(negedge clk_50MHz);
        bif.key_n = 1'b1;
        wait_for(2, 20, "b2b_bs2");
        repeat (5) @(negedge clk_50MHz);
        chk("b2b_bs_count", n_bs - b0, 2);
        chk("b2b_no_bl", n_bl - l0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
